// File: rtl/pov_column_driver.sv
// pov_column_driver: downstream stage of the one-hot column shift register.
//
// Tracks the globe's angular slice, which the hall-sensor index resets and slice_tick
// advances. For each new column, or a new slice under the same column, it reads that
// column's row pixels from a synchronous-read frame buffer. It then drives led_rows and
// led_cols together from registers, so rows and columns always change in the same cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   col_sel     one-hot column select (0 = idle)
//   index       1-cycle revolution-start pulse; forces slice to 0
//   slice_tick  1-cycle pulse; advances the slice (index wins if both are high)
//   mem_rd_en   frame-buffer read strobe, one cycle per fetch
//   mem_addr    read address = slice*COLS + column index; holds while idle
//   mem_data    read data, valid one cycle after mem_rd_en
//   led_rows    registered row pixels
//   led_cols    registered column enables, aligned with led_rows
//   frame_err   sticky flag: a col_sel with two or more bits set was seen
module pov_column_driver #(
  parameter int unsigned COLS   = 6,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned SLICES = 64,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_sel,
  input  logic              index,
  input  logic              slice_tick,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ROWS-1:0]   mem_data,
  output logic [ROWS-1:0]   led_rows,
  output logic [COLS-1:0]   led_cols,
  output logic              frame_err
);

  localparam int unsigned SliceW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;

  // Slice counter
  logic [SliceW-1:0] slice_q, slice_d;
  // Stage 0: registered column select and the column select before it
  logic [COLS-1:0]   col_q, col_d;
  logic [COLS-1:0]   col_prev_q, col_prev_d;
  // Slice used by the most recent fetch, used to detect a slice change under a held column
  logic [SliceW-1:0] fetch_slice_q, fetch_slice_d;
  // Last issued address, held while no fetch is in progress
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Stage 1: column that goes with the data returning from the frame buffer
  logic [COLS-1:0]   pipe_col_q, pipe_col_d;
  logic              pipe_fetch_q, pipe_fetch_d;
  // Stage 2: LED outputs
  logic [ROWS-1:0]   led_rows_q, led_rows_d;
  logic [COLS-1:0]   led_cols_q, led_cols_d;
  logic              err_q, err_d;

  logic              col_one_hot;
  logic              col_sel_multi;
  logic [ColW-1:0]   col_enc;
  logic              fetch;
  logic [ADDR_W-1:0] fetch_addr;

  always_comb begin
    // x & (x - 1) clears the lowest set bit, so it is nonzero exactly when 2+ bits are set.
    col_sel_multi = (col_sel & (col_sel - COLS'(1))) != '0;
    col_one_hot   = (col_q != '0) && ((col_q & (col_q - COLS'(1))) == '0);

    col_enc = '0;
    for (int i = 0; i < int'(COLS); i++) begin
      if (col_q[i]) col_enc = ColW'(i);
    end

    // Index has priority over slice_tick.
    slice_d = slice_q;
    if (index) begin
      slice_d = '0;
    end else if (slice_tick) begin
      slice_d = (slice_q == SliceW'(SLICES - 1)) ? '0 : slice_q + SliceW'(1);
    end

    col_d      = col_sel;
    col_prev_d = col_q;
    err_d      = err_q | col_sel_multi;

    // slice_q already includes any index or tick sampled together with col_q.
    fetch      = col_one_hot && ((col_q != col_prev_q) || (slice_q != fetch_slice_q));
    fetch_addr = ADDR_W'(32'(slice_q) * COLS + 32'(col_enc));

    mem_rd_en     = fetch;
    mem_addr      = fetch ? fetch_addr : addr_q;
    addr_d        = mem_addr;
    fetch_slice_d = fetch ? slice_q : fetch_slice_q;

    // An idle or invalid column travels down the pipe as 0 and blanks the LEDs.
    pipe_col_d   = col_one_hot ? col_q : '0;
    pipe_fetch_d = fetch;

    led_rows_d = led_rows_q;
    led_cols_d = pipe_col_q;
    if (pipe_col_q == '0) begin
      led_rows_d = '0;
    end else if (pipe_fetch_q) begin
      led_rows_d = mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_q       <= '0;
      col_q         <= '0;
      col_prev_q    <= '0;
      fetch_slice_q <= '0;
      addr_q        <= '0;
      pipe_col_q    <= '0;
      pipe_fetch_q  <= 1'b0;
      led_rows_q    <= '0;
      led_cols_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      slice_q       <= slice_d;
      col_q         <= col_d;
      col_prev_q    <= col_prev_d;
      fetch_slice_q <= fetch_slice_d;
      addr_q        <= addr_d;
      pipe_col_q    <= pipe_col_d;
      pipe_fetch_q  <= pipe_fetch_d;
      led_rows_q    <= led_rows_d;
      led_cols_q    <= led_cols_d;
      err_q         <= err_d;
    end
  end

  assign led_rows  = led_rows_q;
  assign led_cols  = led_cols_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_pov_column_driver.sv
module tb_pov_column_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] col_sel = '0;
  logic       index = 1'b0;
  logic       slice_tick = 1'b0;
  logic       mem_rd_en;
  logic [8:0] mem_addr;
  logic [7:0] mem_data = '0;
  logic [7:0] led_rows;
  logic [5:0] led_cols;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pov_column_driver #(
    .COLS(6), .ROWS(8), .SLICES(64), .ADDR_W(9)
  ) dut (
    .clk(clk), .rst(rst), .col_sel(col_sel), .index(index), .slice_tick(slice_tick),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .led_rows(led_rows), .led_cols(led_cols), .frame_err(frame_err)
  );

  // Frame buffer: each word holds its own address plus A0, read one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= 8'(mem_addr) + 8'hA0;
  end

  // Reference model state (integers and plain arithmetic)
  int         m_slice = 0;
  int         m_last_slice = 0;
  logic [5:0] m_col = '0;
  logic [5:0] m_prev = '0;
  logic       m_err = 1'b0;
  logic       m_rd = 1'b0;
  int         m_addr = 0;
  logic [7:0] m_rows = '0;
  logic [5:0] m_cols = '0;
  logic [5:0] p1_col = '0, p2_col = '0;
  logic       p1_fetch = 1'b0, p2_fetch = 1'b0;
  int         p1_addr = 0, p2_addr = 0;

  // Drive one cycle at the negedge, advance the model at the posedge, return at the negedge.
  task automatic step(input logic r, input logic [5:0] c, input logic i, input logic t);
    rst = r; col_sel = c; index = i; slice_tick = t;
    @(posedge clk);
    if (r) begin
      m_slice = 0; m_last_slice = 0; m_col = '0; m_prev = '0; m_err = 1'b0;
      m_rd = 1'b0; m_addr = 0; m_rows = '0; m_cols = '0;
      p1_col = '0; p2_col = '0; p1_fetch = 1'b0; p2_fetch = 1'b0; p1_addr = 0; p2_addr = 0;
    end else begin
      if (p2_col == '0) begin
        m_rows = '0; m_cols = '0;
      end else begin
        if (p2_fetch) m_rows = 8'(p2_addr + 160);
        m_cols = p2_col;
      end
      p2_col = p1_col; p2_fetch = p1_fetch; p2_addr = p1_addr;
      if (i) m_slice = 0;
      else if (t) m_slice = (m_slice + 1) % 64;
      m_prev = m_col;
      m_col  = c;
      if ($countones(c) > 1) m_err = 1'b1;
      m_rd = ($countones(m_col) == 1) && ((m_col != m_prev) || (m_slice != m_last_slice));
      if (m_rd) begin
        m_addr = m_slice * 6 + $clog2(m_col);
        m_last_slice = m_slice;
      end
      p1_col   = ($countones(m_col) == 1) ? m_col : 6'b0;
      p1_fetch = m_rd;
      p1_addr  = m_addr;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 6'($urandom), 1'($urandom), 1'($urandom));
    step(1'b1, 6'($urandom), 1'($urandom), 1'($urandom));
    total++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 9'd0 || led_rows !== 8'd0 || led_cols !== 6'd0 ||
        frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rd=%b addr=%0d rows=%h cols=%b err=%b, want all 0",
               mem_rd_en, mem_addr, led_rows, led_cols, frame_err);
    end
    // Slice must be 0: the first column 1 after reset reads address 1.
    step(1'b0, 6'b000010, 1'b0, 1'b0);
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 9'd1) begin
      bad++;
      $display("FAIL reset_slice0: got rd=%b addr=%0d, want rd=1 addr=1", mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_pipeline();
    step(1'b1, 6'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000001, 1'b0, 1'b0);
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 9'd0) begin
      bad++;
      $display("FAIL pipe_fetch0: got rd=%b addr=%0d, want rd=1 addr=0", mem_rd_en, mem_addr);
    end
    step(1'b0, 6'b000010, 1'b0, 1'b0);
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 9'd1 || led_cols !== 6'b0) begin
      bad++;
      $display("FAIL pipe_fetch1: got rd=%b addr=%0d cols=%b, want rd=1 addr=1 cols=0",
               mem_rd_en, mem_addr, led_cols);
    end
    step(1'b0, 6'b000010, 1'b0, 1'b0);
    total++;
    if (led_rows !== 8'hA0 || led_cols !== 6'b000001 || mem_rd_en !== 1'b0 ||
        mem_addr !== 9'd1) begin
      bad++;
      $display("FAIL pipe_led0: got rows=%h cols=%b rd=%b addr=%0d, want A0 000001 0 1",
               led_rows, led_cols, mem_rd_en, mem_addr);
    end
    step(1'b0, 6'b000010, 1'b0, 1'b0);
    total++;
    if (led_rows !== 8'hA1 || led_cols !== 6'b000010) begin
      bad++;
      $display("FAIL pipe_led1: got rows=%h cols=%b, want A1 000010", led_rows, led_cols);
    end
  endtask

  task automatic test_slice_wrap();
    step(1'b1, 6'b0, 1'b0, 1'b0);
    for (int k = 0; k < 64 + 5; k++) step(1'b0, 6'b0, 1'b0, 1'b1);
    step(1'b0, 6'b000100, 1'b0, 1'b0);
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 9'd32) begin
      bad++;
      $display("FAIL wrap_addr32: got rd=%b addr=%0d, want rd=1 addr=32", mem_rd_en, mem_addr);
    end
    step(1'b0, 6'b000100, 1'b0, 1'b1);
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 9'd38) begin
      bad++;
      $display("FAIL refetch_addr38: got rd=%b addr=%0d, want rd=1 addr=38", mem_rd_en,
               mem_addr);
    end
    step(1'b0, 6'b000100, 1'b0, 1'b0);
    total++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 9'd38 || led_rows !== 8'(32 + 160)) begin
      bad++;
      $display("FAIL hold_addr: got rd=%b addr=%0d rows=%h, want rd=0 addr=38 rows=c0",
               mem_rd_en, mem_addr, led_rows);
    end
  endtask

  task automatic test_index_priority();
    step(1'b1, 6'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 6'b000001, 1'b0, 1'b1);
    step(1'b0, 6'b100000, 1'b1, 1'b1);
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 9'd5) begin
      bad++;
      $display("FAIL index_addr5: got rd=%b addr=%0d, want rd=1 addr=5", mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_frame_err();
    step(1'b1, 6'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000001, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0);
    total++;
    if (mem_rd_en !== 1'b0 || frame_err !== 1'b1) begin
      bad++;
      $display("FAIL err_set: got rd=%b err=%b, want rd=0 err=1", mem_rd_en, frame_err);
    end
    step(1'b0, 6'b000011, 1'b0, 1'b0);
    total++;
    if (led_rows !== 8'hA0 || led_cols !== 6'b000001) begin
      bad++;
      $display("FAIL err_prev_led: got rows=%h cols=%b, want A0 000001", led_rows, led_cols);
    end
    step(1'b0, 6'b000011, 1'b0, 1'b0);
    total++;
    if (led_rows !== 8'h00 || led_cols !== 6'b0) begin
      bad++;
      $display("FAIL err_blank: got rows=%h cols=%b, want 00 000000", led_rows, led_cols);
    end
    step(1'b0, 6'b001000, 1'b0, 1'b0);
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 9'd3 || frame_err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got rd=%b addr=%0d err=%b, want rd=1 addr=3 err=1",
               mem_rd_en, mem_addr, frame_err);
    end
  endtask

  task automatic test_reset_mid_fetch();
    step(1'b1, 6'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000010, 1'b0, 1'b0);
    step(1'b1, 6'b000010, 1'b0, 1'b0);
    total++;
    if (led_rows !== 8'h00 || led_cols !== 6'b0 || mem_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_0: got rows=%h cols=%b rd=%b, want 00 0 0",
               led_rows, led_cols, mem_rd_en);
    end
    step(1'b0, 6'b000000, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b0);
    total++;
    if (led_rows !== 8'h00 || led_cols !== 6'b0) begin
      bad++;
      $display("FAIL rst_no_stale: got rows=%h cols=%b, want 00 0", led_rows, led_cols);
    end
    step(1'b0, 6'b010000, 1'b0, 1'b0);
    total++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 9'd4) begin
      bad++;
      $display("FAIL rst_refetch: got rd=%b addr=%0d, want rd=1 addr=4", mem_rd_en, mem_addr);
    end
    step(1'b0, 6'b010000, 1'b0, 1'b0);
    step(1'b0, 6'b010000, 1'b0, 1'b0);
    total++;
    if (led_rows !== 8'hA4 || led_cols !== 6'b010000) begin
      bad++;
      $display("FAIL rst_refetch_led: got rows=%h cols=%b, want A4 010000", led_rows, led_cols);
    end
  endtask

  task automatic test_random();
    logic [5:0] c;
    int         sel;
    step(1'b1, 6'b0, 1'b0, 1'b0);
    c = '0;
    for (int k = 0; k < 600; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel >= 4 && sel < 8) c = 6'(1 << $urandom_range(0, 5));
      else if (sel == 8) c = '0;
      else if (sel == 9) c = 6'($urandom);
      step(($urandom_range(0, 79) == 0), c, ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0));
      total++;
      if (mem_rd_en !== m_rd || (m_rd && mem_addr !== 9'(m_addr))) begin
        bad++;
        $display("FAIL rand_fetch[%0d]: got rd=%b addr=%0d, want rd=%b addr=%0d",
                 k, mem_rd_en, mem_addr, m_rd, m_addr);
      end
      total++;
      if (mem_addr !== 9'(m_addr)) begin
        bad++;
        $display("FAIL rand_addr[%0d]: got %0d, want %0d", k, mem_addr, m_addr);
      end
      total++;
      if (led_rows !== m_rows || led_cols !== m_cols) begin
        bad++;
        $display("FAIL rand_led[%0d]: got rows=%h cols=%b, want rows=%h cols=%b",
                 k, led_rows, led_cols, m_rows, m_cols);
      end
      total++;
      if (frame_err !== m_err) begin
        bad++;
        $display("FAIL rand_err[%0d]: got %b, want %b", k, frame_err, m_err);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pipeline();
    test_slice_wrap();
    test_index_priority();
    test_frame_err();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
